// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples sck/ws/sd on clk, deserializes MSB-first left/right
// words and presents completed stereo pairs through a valid/ready handshake.
module i2s_receiver #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_sck_prev;
  logic                   r_evt;
  logic                   r_ws_smp;
  logic                   r_sd_smp;

  logic                   w_sck_s;
  logic                   w_ws_s;
  logic                   w_sd_s;

  logic [0:0]             r_state,      w_state_nxt;
  logic [CNT_W-1:0]       r_cnt,        w_cnt_nxt;
  logic [DATA_WIDTH-1:0]  r_shift,      w_shift_nxt;
  logic                   r_ws_prev,    w_ws_prev_nxt;
  logic                   r_left_vld,   w_left_vld_nxt;
  logic [DATA_WIDTH-1:0]  r_left_hold,  w_left_hold_nxt;
  logic [DATA_WIDTH-1:0]  r_left_data,  w_left_data_nxt;
  logic [DATA_WIDTH-1:0]  r_right_data, w_right_data_nxt;
  logic                   r_valid,      w_valid_nxt;
  logic                   r_ferr,       w_ferr_nxt;
  logic                   r_overrun,    w_overrun_nxt;

  logic                   w_trans;
  logic                   w_room;
  logic                   w_short;
  logic [DATA_WIDTH-1:0]  w_word;

  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
  assign w_ws_s  = r_ws_sync[SYNC_STAGES-1];
  assign w_sd_s  = r_sd_sync[SYNC_STAGES-1];

  // Synchronizers plus one registered stage holding the sck rising-edge event and its samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
      r_sck_prev <= 1'b0;
      r_evt      <= 1'b0;
      r_ws_smp   <= 1'b0;
      r_sd_smp   <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws};
      r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], sd};
      r_sck_prev <= w_sck_s;
      r_evt      <= w_sck_s & ~r_sck_prev;
      r_ws_smp   <= w_ws_s;
      r_sd_smp   <= w_sd_s;
    end
  end

  assign w_trans = r_ws_smp ^ r_ws_prev;
  assign w_room  = r_cnt < CNT_W'(DATA_WIDTH);
  assign w_short = r_cnt < CNT_W'(DATA_WIDTH - 1);
  assign w_word  = w_room ? {r_shift[DATA_WIDTH-2:0], r_sd_smp} : r_shift;

  // Framing FSM and output handshake; publish takes priority over a same-cycle transfer
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shift_nxt      = r_shift;
    w_ws_prev_nxt    = r_ws_prev;
    w_left_vld_nxt   = r_left_vld;
    w_left_hold_nxt  = r_left_hold;
    w_left_data_nxt  = r_left_data;
    w_right_data_nxt = r_right_data;
    w_valid_nxt      = r_valid;
    w_ferr_nxt       = 1'b0;
    w_overrun_nxt    = r_overrun;

    if (r_valid && out_ready) begin
      w_valid_nxt = 1'b0;
    end

    if (r_evt) begin
      w_ws_prev_nxt = r_ws_smp;
      case (r_state)
        ST_SYNC: begin
          if (r_ws_prev && !r_ws_smp) begin
            w_state_nxt    = ST_RECV;
            w_cnt_nxt      = '0;
            w_left_vld_nxt = 1'b0;
          end
        end
        ST_RECV: begin
          if (!w_trans) begin
            if (w_room) begin
              w_shift_nxt = w_word;
              w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
          end else begin
            w_shift_nxt = w_word;
            w_cnt_nxt   = '0;
            if (w_short) begin
              w_ferr_nxt = 1'b1;
              if (!r_ws_prev) begin
                w_left_vld_nxt = 1'b0;
              end
            end else if (!r_ws_prev) begin
              w_left_hold_nxt = w_word;
              w_left_vld_nxt  = 1'b1;
            end else if (r_left_vld) begin
              w_left_data_nxt  = r_left_hold;
              w_right_data_nxt = w_word;
              w_valid_nxt      = 1'b1;
              w_left_vld_nxt   = 1'b0;
              if (r_valid && !out_ready) begin
                w_overrun_nxt = 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_SYNC;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_ws_prev    <= 1'b0;
      r_left_vld   <= 1'b0;
      r_left_hold  <= '0;
      r_left_data  <= '0;
      r_right_data <= '0;
      r_valid      <= 1'b0;
      r_ferr       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_ws_prev    <= w_ws_prev_nxt;
      r_left_vld   <= w_left_vld_nxt;
      r_left_hold  <= w_left_hold_nxt;
      r_left_data  <= w_left_data_nxt;
      r_right_data <= w_right_data_nxt;
      r_valid      <= w_valid_nxt;
      r_ferr       <= w_ferr_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign left_data   = r_left_data;
  assign right_data  = r_right_data;
  assign out_valid   = r_valid;
  assign frame_error = r_ferr;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: word-level reference model of the I2S framing rules with
// a per-cycle output comparison, plus directed literal checks and randomized frames.
module tb_i2s_receiver;

  localparam int unsigned DW  = 16;
  localparam int unsigned SS  = 2;
  localparam int unsigned LAT = SS + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sck = 1'b0;
  logic          ws = 1'b0;
  logic          sd = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          out_valid;
  logic          frame_error;
  logic          overrun;

  always #5 clk = ~clk;

  i2s_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sck(sck), .ws(ws), .sd(sd),
    .left_data(left_data), .right_data(right_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_error(frame_error), .overrun(overrun)
  );

  typedef struct {
    int            c;
    bit            is_pub;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } act_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Word-level model state
  act_t          sched_q[$];
  bit            slot_q[$];
  bit            m_recv = 1'b0;
  bit            m_wsp = 1'b0;
  bit            m_lv = 1'b0;
  logic [DW-1:0] m_lhold = '0;

  // Expected outputs
  bit            e_valid = 1'b0;
  bit            e_ferr = 1'b0;
  bit            e_ovr = 1'b0;
  logic [DW-1:0] e_l = '0;
  logic [DW-1:0] e_r = '0;

  int            valid_cnt = 0;
  int            ferr_cnt = 0;
  int            obs_cyc = 0;
  logic [DW-1:0] obs_l = '0;
  logic [DW-1:0] obs_r = '0;
  int            last_evt_cyc = 0;
  bit            rand_rdy = 1'b0;
  bit            rand_phase = 1'b0;
  bit            pre_valid;
  act_t          act;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Applies the I2S framing rules to one sampled bit; results become visible LAT cycles later
  task automatic m_event(input bit b_ws, input bit b_sd, input int c);
    int            n;
    logic [DW-1:0] w;
    act_t          a;
    if (!m_recv) begin
      if (m_wsp && !b_ws) begin
        m_recv = 1'b1;
        slot_q.delete();
        m_lv = 1'b0;
      end
    end else begin
      slot_q.push_back(b_sd);
      if (b_ws != m_wsp) begin
        n = slot_q.size();
        w = '0;
        if (n >= int'(DW)) begin
          for (int i = 0; i < int'(DW); i++) w = {w[DW-2:0], slot_q[i]};
        end
        if (n < int'(DW)) begin
          a = '{c + int'(LAT), 1'b0, '0, '0};
          sched_q.push_back(a);
          if (!m_wsp) m_lv = 1'b0;
        end else if (!m_wsp) begin
          m_lhold = w;
          m_lv = 1'b1;
        end else if (m_lv) begin
          a = '{c + int'(LAT), 1'b1, m_lhold, w};
          sched_q.push_back(a);
          m_lv = 1'b0;
        end
        slot_q.delete();
      end
    end
    m_wsp = b_ws;
  endtask

  // Per-cycle comparison against the model
  always begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      e_ovr   = 1'b0;
      e_l     = '0;
      e_r     = '0;
    end else begin
      pre_valid = e_valid;
      e_ferr = 1'b0;
      if (pre_valid && out_ready) e_valid = 1'b0;
      while (sched_q.size() > 0 && sched_q[0].c <= cyc) begin
        act = sched_q.pop_front();
        if (act.is_pub) begin
          if (pre_valid && !out_ready) e_ovr = 1'b1;
          e_valid = 1'b1;
          e_l = act.l;
          e_r = act.r;
        end else begin
          e_ferr = 1'b1;
        end
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("frame_error", 64'(frame_error), 64'(e_ferr));
    chk("overrun", 64'(overrun), 64'(e_ovr));
    chk("left_data", 64'(left_data), 64'(e_l));
    chk("right_data", 64'(right_data), 64'(e_r));
    if (out_valid) begin
      valid_cnt++;
      obs_cyc = cyc;
      obs_l = left_data;
      obs_r = right_data;
    end
    if (frame_error) ferr_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_bit(input bit b_ws, input bit b_sd);
    int hi;
    int lo;
    hi = rand_phase ? int'($urandom_range(2, 4)) : 3;
    lo = rand_phase ? int'($urandom_range(2, 4)) : 3;
    ws = b_ws;
    sd = b_sd;
    repeat (lo) tick();
    sck = 1'b1;
    last_evt_cyc = cyc;
    m_event(b_ws, b_sd, cyc);
    repeat (hi) tick();
    sck = 1'b0;
  endtask

  // MSB-first word; the LSB already carries the next channel's ws
  task automatic send_word(input bit ch, input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? ~ch : ch, v[i]);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_word(1'b0, 64'(l), int'(DW));
    send_word(1'b1, 64'(r), int'(DW));
  endtask

  task automatic do_reset(input int n, input bit toggle);
    tick();
    reset = 1'b1;
    m_recv = 1'b0;
    m_wsp = 1'b0;
    m_lv = 1'b0;
    slot_q.delete();
    sched_q.delete();
    for (int i = 0; i < n; i++) begin
      if (toggle) {sck, ws, sd} = 3'($urandom);
      tick();
    end
    sck = 1'b0;
    reset = 1'b0;
  endtask

  int v0;
  int f0;
  int rl;
  int nl;
  int nr;

  function automatic int pick_len();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 6) return int'(DW);
    if (k < 8) return int'($urandom_range(DW + 1, DW + 8));
    return int'($urandom_range(2, DW - 1));
  endfunction

  initial begin
    // Reset with inputs toggling
    do_reset(3, 1'b1);
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ferr", 64'(frame_error), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_left", 64'(left_data), 64'd0);
    chk("rst_right", 64'(right_data), 64'd0);

    // A complete pair before any 1->0 ws frame must not be delivered
    v0 = valid_cnt;
    send_frame(16'h1111, 16'h2222);
    repeat (8) tick();
    chk("nosync_cnt", 64'(valid_cnt - v0), 64'd0);

    // Nominal frames, ready held high
    v0 = valid_cnt;
    send_frame(16'hA5C3, 16'h1234);
    rl = last_evt_cyc;
    repeat (8) tick();
    chk("nom_cnt", 64'(valid_cnt - v0), 64'd1);
    chk("nom_left", 64'(obs_l), 64'hA5C3);
    chk("nom_right", 64'(obs_r), 64'h1234);
    chk("nom_latency", 64'(obs_cyc - rl), 64'd4);
    send_frame(16'h0001, 16'h8000);
    repeat (8) tick();
    chk("nom2_left", 64'(obs_l), 64'h0001);
    chk("nom2_right", 64'(obs_r), 64'h8000);
    send_frame(16'hFFFF, 16'h0000);
    repeat (8) tick();
    chk("nom3_left", 64'(obs_l), 64'hFFFF);
    chk("nom3_right", 64'(obs_r), 64'h0000);
    chk("nom3_cnt", 64'(valid_cnt - v0), 64'd3);

    // Wide 32-bit slots: excess LSBs dropped
    f0 = ferr_cnt;
    send_word(1'b0, 64'hBEEFFFFF, 32);
    send_word(1'b1, 64'h0F0F0000, 32);
    repeat (8) tick();
    chk("wide_left", 64'(obs_l), 64'hBEEF);
    chk("wide_right", 64'(obs_r), 64'h0F0F);
    chk("wide_ferr", 64'(ferr_cnt - f0), 64'd0);

    // Short left word
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_word(1'b0, 64'h2AB, 10);
    send_word(1'b1, 64'h5555, int'(DW));
    repeat (8) tick();
    chk("short_ferr", 64'(ferr_cnt - f0), 64'd1);
    chk("short_novalid", 64'(valid_cnt - v0), 64'd0);
    send_frame(16'h6789, 16'hABCD);
    repeat (8) tick();
    chk("short_next_left", 64'(obs_l), 64'h6789);
    chk("short_next_right", 64'(obs_r), 64'hABCD);

    // Backpressure across two frames
    out_ready = 1'b0;
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    repeat (8) tick();
    chk("bp_ovr", 64'(overrun), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_left", 64'(left_data), 64'h3333);
    chk("bp_right", 64'(right_data), 64'h4444);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_ovr_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of a left word
    send_word(1'b1, 64'h0, 4);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'(i));
    do_reset(2, 1'b0);
    v0 = valid_cnt;
    repeat (8) tick();
    chk("midrst_ovr", 64'(overrun), 64'd0);
    chk("midrst_novalid", 64'(valid_cnt - v0), 64'd0);
    send_word(1'b1, 64'h0, 4);
    send_frame(16'hCAFE, 16'hF00D);
    repeat (8) tick();
    chk("midrst_cnt", 64'(valid_cnt - v0), 64'd1);
    chk("midrst_left", 64'(obs_l), 64'hCAFE);
    chk("midrst_right", 64'(obs_r), 64'hF00D);

    // Randomized slots, data, sck phases and consumer readiness
    rand_rdy = 1'b1;
    rand_phase = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nl = pick_len();
      nr = pick_len();
      send_word(1'b0, {32'($urandom), 32'($urandom)}, nl);
      send_word(1'b1, {32'($urandom), 32'($urandom)}, nr);
    end
    rand_rdy = 1'b0;
    rand_phase = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
